// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM with ALU-select decode for the datapath ALU.
// Optional MIPS_MC_OVF_TRAP_EN: signed-overflow trap on add/sub/addi (adds ovf_trap port).
module mips_mc_control #(
   parameter int unsigned SEL_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                ovf,
   output logic                pc_en,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                imm_zext,
   output logic [1:0]          pc_src,
`ifdef MIPS_MC_OVF_TRAP_EN
   output logic                ovf_trap,
`endif
   output logic [SEL_BITS-1:0] alu_sel,
   output logic                illegal_op,
   output logic                instr_done
);

   localparam logic [SEL_BITS-1:0] ALU_ADD  = SEL_BITS'(4'b0000);
   localparam logic [SEL_BITS-1:0] ALU_SUB  = SEL_BITS'(4'b0001);
   localparam logic [SEL_BITS-1:0] ALU_SLL  = SEL_BITS'(4'b0010);
   localparam logic [SEL_BITS-1:0] ALU_SRL  = SEL_BITS'(4'b0011);
   localparam logic [SEL_BITS-1:0] ALU_SLLV = SEL_BITS'(4'b0100);
   localparam logic [SEL_BITS-1:0] ALU_SRLV = SEL_BITS'(4'b0101);
   localparam logic [SEL_BITS-1:0] ALU_SRA  = SEL_BITS'(4'b0110);
   localparam logic [SEL_BITS-1:0] ALU_AND  = SEL_BITS'(4'b0111);
   localparam logic [SEL_BITS-1:0] ALU_OR   = SEL_BITS'(4'b1000);
   localparam logic [SEL_BITS-1:0] ALU_XOR  = SEL_BITS'(4'b1001);
   localparam logic [SEL_BITS-1:0] ALU_SRAV = SEL_BITS'(4'b1011);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_ITYPE_EX = 4'd8,
      S_ITYPE_WB = 4'd9,
      S_BEQ_EX   = 4'd10,
      S_BNE_EX   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   state_t state_q, state_d;
   logic   pc_write, branch_eq, branch_ne;

   function automatic logic rtype_ok(input logic [5:0] f);
      case (f)
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

   function automatic logic [SEL_BITS-1:0] rtype_sel(input logic [5:0] f);
      case (f)
         6'h22, 6'h23: return ALU_SUB;
         6'h24:        return ALU_AND;
         6'h25:        return ALU_OR;
         6'h26:        return ALU_XOR;
         6'h00:        return ALU_SLL;
         6'h02:        return ALU_SRL;
         6'h03:        return ALU_SRA;
         6'h04:        return ALU_SLLV;
         6'h06:        return ALU_SRLV;
         6'h07:        return ALU_SRAV;
         default:      return ALU_ADD;
      endcase
   endfunction

   function automatic logic [SEL_BITS-1:0] itype_sel(input logic [5:0] o);
      case (o)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_XORI: return ALU_XOR;
         default: return ALU_ADD;
      endcase
   endfunction

`ifdef MIPS_MC_OVF_TRAP_EN
   logic ovf_q, ovf_d;
`else
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif

   // State register; the trap flag rides alongside it when enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
`ifdef MIPS_MC_OVF_TRAP_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
`ifdef MIPS_MC_OVF_TRAP_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = S_FETCH;
`ifdef MIPS_MC_OVF_TRAP_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = rtype_ok(funct) ? S_RTYPE_EX : S_FETCH;
               OP_BEQ:       state_d = S_BEQ_EX;
               OP_BNE:       state_d = S_BNE_EX;
               OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: state_d = S_ITYPE_EX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_RTYPE_EX: begin
            state_d = S_RTYPE_WB;
`ifdef MIPS_MC_OVF_TRAP_EN
            ovf_d   = ovf & ((funct == 6'h20) | (funct == 6'h22));
`endif
         end
         S_ITYPE_EX: begin
            state_d = S_ITYPE_WB;
`ifdef MIPS_MC_OVF_TRAP_EN
            ovf_d   = ovf & (op == OP_ADDI);
`endif
         end
         default:  state_d = S_FETCH;
      endcase
   end

   // Output decode; reset masks every strobe and select.
   always_comb begin
      pc_write   = 1'b0;
      branch_eq  = 1'b0;
      branch_ne  = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      pc_src     = 2'b00;
      alu_sel    = ALU_ADD;
      illegal_op = 1'b0;
      instr_done = 1'b0;
`ifdef MIPS_MC_OVF_TRAP_EN
      ovf_trap   = 1'b0;
`endif
      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (op)
               OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
               OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: illegal_op = 1'b0;
               OP_RTYPE: illegal_op = ~rtype_ok(funct);
               default:  illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_RTYPE_EX: begin
            alu_src_a = 1'b1;
            alu_sel   = rtype_sel(funct);
         end
         S_RTYPE_WB: begin
            reg_dst    = 1'b1;
            instr_done = 1'b1;
`ifdef MIPS_MC_OVF_TRAP_EN
            reg_write  = ~ovf_q;
            ovf_trap   = ovf_q;
`else
            reg_write  = 1'b1;
`endif
         end
         S_ITYPE_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_sel   = itype_sel(op);
            imm_zext  = (op == OP_ANDI) | (op == OP_ORI) | (op == OP_XORI);
         end
         S_ITYPE_WB: begin
            instr_done = 1'b1;
`ifdef MIPS_MC_OVF_TRAP_EN
            reg_write  = ~ovf_q;
            ovf_trap   = ovf_q;
`else
            reg_write  = 1'b1;
`endif
         end
         S_BEQ_EX, S_BNE_EX: begin
            alu_src_a  = 1'b1;
            alu_sel    = ALU_SUB;
            pc_src     = 2'b01;
            branch_eq  = (state_q == S_BEQ_EX);
            branch_ne  = (state_q == S_BNE_EX);
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase

      pc_en = pc_write | (branch_eq & zero) | (branch_ne & ~zero);

      if (rst) begin
         pc_en      = 1'b0;
         iord       = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         imm_zext   = 1'b0;
         pc_src     = 2'b00;
         alu_sel    = ALU_ADD;
         illegal_op = 1'b0;
         instr_done = 1'b0;
`ifdef MIPS_MC_OVF_TRAP_EN
         ovf_trap   = 1'b0;
`endif
      end
   end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM plus ALU-select decode; sits directly upstream of the datapath ALU and drives its 4-bit operation select.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the PC, memory, IR, register-file and ALU-operand mux controls.

Parameters:
- SEL_BITS, 4, width of alu_sel; must match the ALU select width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zero  in  1  ALU zero flag
- ovf  in  1  ALU signed-overflow flag
- pc_en  out  1  PC load enable = pc_write | (branch_eq & zero) | (branch_ne & ~zero)
- iord  out  1  0 = memory address is PC; 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  0 = rt; 1 = rd
- mem_to_reg  out  1  0 = ALUOut; 1 = MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC; 1 = A
- alu_src_b  out  2  00 B, 01 constant 4, 10 extended imm, 11 imm<<2
- imm_zext  out  1  1 = zero-extend imm (andi/ori/xori); 0 = sign-extend
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_sel  out  SEL_BITS  ALU operation select
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported op or funct
- instr_done  out  1  one-cycle pulse in an instruction's final state

Behaviour:
- State register only; all outputs are Moore decodes of state, except pc_en, which is combinational from state, zero and the branch type.
- rst is sampled on the clk edge and loads state = FETCH.
- While rst = 1, all strobes and enables are forced to 0: pc_en, mem_write, ir_write, reg_write, illegal_op, instr_done. Mux selects are forced to 0 and alu_sel to 0000.
- ALU codes:
  - add 0000, sub 0001, sll 0010, srl 0011, sllv 0100, srlv 0101
  - sra 0110, and 0111, or 1000, xor 1001, srav 1011
- FETCH:
  - iord = 0, ir_write = 1, alu_src_a = 0, alu_src_b = 01, alu_sel = add, pc_src = 00, pc_write = 1.
  - Next state: DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_sel = add (branch target into ALUOut).
  - Dispatch on op:
    - 0x23 / 0x2B -> MEMADR
    - 0x00 -> RTYPE_EX
    - 0x04 -> BEQ_EX
    - 0x05 -> BNE_EX
    - 0x08 / 0x09 / 0x0C / 0x0D / 0x0E -> ITYPE_EX
    - 0x02 -> JUMP
    - otherwise: illegal_op = 1 and next state FETCH
- R-type funct map (anything else -> illegal_op, FETCH):
  - 0x20 / 0x21 add, 0x22 / 0x23 sub, 0x24 and, 0x25 or, 0x26 xor
  - 0x00 sll, 0x02 srl, 0x03 sra, 0x04 sllv, 0x06 srlv, 0x07 srav
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_sel = add. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1 -> MEMWB.
- MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1, instr_done = 1 -> FETCH.
- MEMWR: iord = 1, mem_write = 1, instr_done = 1 -> FETCH.
- RTYPE_EX: alu_src_a = 1, alu_src_b = 00, alu_sel from funct -> RTYPE_WB.
- RTYPE_WB: reg_dst = 1, mem_to_reg = 0, reg_write = 1, instr_done = 1 -> FETCH.
- ITYPE_EX:
  - alu_src_a = 1, alu_src_b = 10.
  - addi / addiu: add, imm_zext = 0. andi: and, imm_zext = 1. ori: or, imm_zext = 1. xori: xor, imm_zext = 1.
  - Next: ITYPE_WB.
- ITYPE_WB: reg_dst = 0, mem_to_reg = 0, reg_write = 1, instr_done = 1 -> FETCH.
- BEQ_EX / BNE_EX: alu_src_a = 1, alu_src_b = 00, alu_sel = sub, pc_src = 01, branch_eq or branch_ne asserted, instr_done = 1 -> FETCH.
- JUMP: pc_src = 10, pc_write = 1, instr_done = 1 -> FETCH.
- op and funct are held stable by the IR from DECODE through writeback.
- Only DECODE and the EX states read them; in R-type and I-type EX states alu_sel is re-decoded from the registered IR.
- Latencies in cycles, FETCH through last state: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3.
- rst asserted in any state aborts the instruction: no reg_write or mem_write in the reset cycle, and FETCH resumes on the first cycle after rst drops.
- Unreachable state encodings -> FETCH.

Optional Feature:
- Macro: MIPS_MC_OVF_TRAP_EN.
- Defined:
  - RTYPE_EX for funct 0x20 / 0x22 and ITYPE_EX for op 0x08 register ovf.
  - If ovf = 1, the following WB state forces reg_write = 0, still pulses instr_done, and additionally pulses output ovf_trap (1 bit, added port).
  - addu, subu and addiu never trap.
- Undefined: ovf is ignored and the ovf_trap port is absent.

Test Plan:
- rst = 1 for 2 cycles, then 0 -> state FETCH; the first cycle after release shows ir_write = 1, pc_en = 1, alu_sel = 0000, alu_src_b = 01.
- op = 0x23 (lw) -> 5 cycles. MEMADR alu_src_b = 10. MEMRD iord = 1. MEMWB reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1.
- op = 0x00, funct = 0x07 (srav) -> RTYPE_EX alu_sel = 1011; RTYPE_WB reg_dst = 1, reg_write = 1. Repeat with funct = 0x03 -> 0110 and funct = 0x24 -> 0111.
- op = 0x04, zero = 1 -> BEQ_EX pc_en = 1, pc_src = 01, alu_sel = 0001. zero = 0 -> pc_en = 0. op = 0x05 gives the inverse.
- op = 0x0D (ori) -> ITYPE_EX alu_sel = 1000, imm_zext = 1. op = 0x3F -> illegal_op pulse in DECODE, next state FETCH, no reg_write.
- op = 0x00, funct = 0x20, assert rst in RTYPE_EX -> no reg_write. With MIPS_MC_OVF_TRAP_EN and ovf = 1 instead: reg_write = 0 and ovf_trap = 1 in RTYPE_WB.
